fifo_rd_ctrl: RTL and testbench
===============================

# fifo_rd_ctrl

Read-side controller for the dual-clock FIFO, running entirely in the read clock domain. It synchronizes the Gray-coded write pointer and maintains the read pointer and empty flag. It issues reads to the FIFO memory array and hides the array's one-cycle registered read latency behind a valid/ready output stream with a two-entry buffer. The write pointer logic and the memory array are separate blocks.

## Interface
- ADDR_WIDTH, 3, memory address width; FIFO depth = 2^ADDR_WIDTH
- DATA_WIDTH, 8, data word width
- r_clk  in  1  read-domain clock; all state on rising edge
- r_rst_n  in  1  asynchronous, active-low reset
- wptr_gray_async  in  ADDR_WIDTH+1  Gray write pointer from write domain, unsynchronized
- rptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, to write-domain synchronizer
- r_empty  out  1  FIFO empty as seen by read domain
- mem_r_en  out  1  read enable to memory array
- mem_r_addr  out  ADDR_WIDTH  read address to memory array
- mem_r_data  in  DATA_WIDTH  memory read data, valid the cycle after mem_r_en
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts word
- out_data  out  DATA_WIDTH  head-of-stream word

## Operation
- Sync: wptr_gray_async passes through 2 flops (wq1, wq2); only wq2 is used.
- Read pointer: binary rbin (ADDR_WIDTH+1 bits) wraps modulo 2^(ADDR_WIDTH+1). rptr_gray = rbin ^ (rbin >> 1), registered. mem_r_addr = rbin[ADDR_WIDTH-1:0].
- r_empty = (rptr_gray == wq2), combinational from registers.
- Output buffer: head (out_data) plus one skid entry; occ = 0..2. pend = 1 when a read was issued last cycle.
- pop = out_valid & out_ready.
- Issue condition: mem_r_en = !r_empty & (occ + pend - pop < 2). On issue, rbin increments and pend is set for the next cycle.
- When pend is high, mem_r_data is written into the head if the head is empty or popping, otherwise into the skid entry. When pend is low, mem_r_data is ignored.
- On pop, the skid entry, if occupied, moves to the head.
- Ordering is strict FIFO: no loss, no duplication.
- The full flag is not computed here.

## Timing
- Reset values: wq1 = wq2 = 0, rbin = 0, rptr_gray = 0, r_empty = 1, mem_r_en = 0, mem_r_addr = 0, pend = 0, occ = 0, out_valid = 0, out_data = 0.
- Write-pointer change to r_empty deasserting: 2 r_clk edges.
- mem_r_en asserted in cycle N: data captured at the end of N+1, out_valid high in N+2.
- rptr_gray updates the cycle after issue.
- Throughput is 1 word/cycle with out_ready held high.
- When out_valid is high and out_ready is low, out_data is held stable.
- At most 2 reads are outstanding against a stalled consumer (occ + pend ≤ 2).
- Wrap: rbin 2^(ADDR_WIDTH+1)-1 → 0. With ADDR_WIDTH = 3, rptr_gray goes 1000 → 0000 and the address goes 7 → 0. No spurious empty at wrap.
- Simultaneous capture and pop with occ = 1: the new word goes to the head and occ stays 1.
- Reset asserted mid-operation: all state clears immediately (asynchronous), including any in-flight read. After release the pointer restarts at 0.

## Structure
- Shared package fifo_pkg holds the bin2gray function and the default ADDR_WIDTH/DATA_WIDTH constants, reused by the write-side controller.
- One sub-module, sync_2ff (parameter WIDTH), performs the pointer synchronization; the write side reuses it.

## Test plan
- Reset: r_rst_n low → r_empty = 1, out_valid = 0, rptr_gray = 0, mem_r_en = 0; these hold after release while wptr_gray_async = 0.
- Single word: memory[0] = 0xA5, wptr_gray_async 0000 → 0001 → r_empty falls 2 edges later; mem_r_en for 1 cycle with addr 0; out_valid with out_data = 0xA5 2 cycles later; rptr_gray = 0001; r_empty = 1 again.
- Streaming: 8 words 0x10..0x17, wptr_gray = 1100, out_ready = 1 → mem_r_en for 8 consecutive cycles with addr 0..7; out_valid for 8 consecutive cycles in order; final rptr_gray = 1100.
- Backpressure: 5 words available, out_ready = 0 → exactly 2 reads issued, out_data holds the first word; raise out_ready → remaining 4 words delivered in order with no gaps after restart.
- Wrap: 20 words in bursts of 8/8/4 with random out_ready → addresses wrap 7 → 0, rptr_gray passes 1000 → 0000, and data order is preserved.
- Reset mid-burst with pend = 1 → outputs go to reset values immediately; after release, the first read is issued at addr 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers.
package fifo_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;
    localparam int PTR_MAX_W  = 32;

    // Callers zero-extend into the wide form and cast the result back down.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(
        input logic [PTR_MAX_W-1:0] i_bin
    );
        return i_bin ^ (i_bin >> 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end

    assign o_q = r_q2;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: pointer sync, empty flag, and a two-entry
// output buffer that hides the memory's registered read latency.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF
) (
    input  logic                  r_clk,
    input  logic                  r_rst_n,
    input  logic [ADDR_WIDTH:0]   wptr_gray_async,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  r_empty,
    output logic                  mem_r_en,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         w_wq2;
    logic [PW-1:0]         r_rbin;
    logic [PW-1:0]         w_rbin_next;
    logic [PW-1:0]         r_rptr_gray;
    logic [1:0]            r_occ;
    logic [1:0]            w_occ_next;
    logic                  r_pend;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_inflight;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_skid;
    logic [DATA_WIDTH-1:0] w_head_next;
    logic [DATA_WIDTH-1:0] w_skid_next;

    sync_2ff #(
        .WIDTH(PW)
    ) u_wsync (
        .i_clk  (r_clk),
        .i_rst_n(r_rst_n),
        .i_d    (wptr_gray_async),
        .o_q    (w_wq2)
    );

    assign r_empty    = (r_rptr_gray == w_wq2);
    assign rptr_gray  = r_rptr_gray;
    assign out_valid  = (r_occ != 2'd0);
    assign out_data   = r_head;
    assign w_pop      = out_valid & out_ready;
    assign w_inflight = {1'b0, r_occ} + {2'b0, r_pend} - {2'b0, w_pop};
    assign w_issue    = !r_empty && (w_inflight < 3'd2);
    assign mem_r_en   = w_issue;
    assign mem_r_addr = r_rbin[ADDR_WIDTH-1:0];
    assign w_rbin_next = r_rbin + PW'(w_issue);

    // When popping a full buffer, the skid word must reach the head first
    // so the returning read lands behind it.
    always_comb begin
        w_occ_next  = r_occ;
        w_head_next = r_head;
        w_skid_next = r_skid;
        case ({w_pop, r_pend})
            2'b11: begin
                if (r_occ == 2'd2) begin
                    w_head_next = r_skid;
                    w_skid_next = mem_r_data;
                end else begin
                    w_head_next = mem_r_data;
                end
            end
            2'b10: begin
                if (r_occ == 2'd2) begin
                    w_head_next = r_skid;
                end
                w_occ_next = r_occ - 2'd1;
            end
            2'b01: begin
                if (r_occ == 2'd0) begin
                    w_head_next = mem_r_data;
                end else begin
                    w_skid_next = mem_r_data;
                end
                w_occ_next = r_occ + 2'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_rbin      <= '0;
            r_rptr_gray <= '0;
            r_pend      <= 1'b0;
            r_occ       <= 2'd0;
            r_head      <= '0;
            r_skid      <= '0;
        end else begin
            r_rbin      <= w_rbin_next;
            r_rptr_gray <= PW'(bin2gray(PTR_MAX_W'(w_rbin_next)));
            r_pend      <= w_issue;
            r_occ       <= w_occ_next;
            r_head      <= w_head_next;
            r_skid      <= w_skid_next;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomized bench for fifo_rd_ctrl with a queue-based reference model.
module tb_fifo_rd_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          r_clk = 1'b0;
    logic          r_rst_n = 1'b0;
    logic [PW-1:0] wptr_gray_async = '0;
    logic [PW-1:0] rptr_gray;
    logic          r_empty;
    logic          mem_r_en;
    logic [AW-1:0] mem_r_addr;
    logic [DW-1:0] mem_r_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;

    always #5 r_clk = ~r_clk;

    fifo_rd_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .r_clk          (r_clk),
        .r_rst_n        (r_rst_n),
        .wptr_gray_async(wptr_gray_async),
        .rptr_gray      (rptr_gray),
        .r_empty        (r_empty),
        .mem_r_en       (mem_r_en),
        .mem_r_addr     (mem_r_addr),
        .mem_r_data     (mem_r_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
    );

    // Memory array with one-cycle registered read
    logic [DW-1:0] tbmem [DEPTH];
    always @(posedge r_clk) if (mem_r_en) mem_r_data <= tbmem[mem_r_addr];

    function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model state
    logic [PW-1:0] m_rcnt = '0;
    logic [PW-1:0] m_wq1 = '0;
    logic [PW-1:0] m_wq2 = '0;
    logic [DW-1:0] m_buf [$];
    bit            m_p1 = 0;
    logic [DW-1:0] m_p1_data = '0;
    logic [PW-1:0] wbin = '0;
    logic [DW-1:0] got [$];
    int            n_issue = 0;
    logic [PW-1:0] prev_g = '0;
    bit            seen_gwrap = 0;
    bit            rand_mode = 0;

    bit e_empty, e_valid, e_pop, e_en;

    initial forever begin
        @(negedge r_clk);
        if (!r_rst_n) begin
            chk("rst_empty", r_empty, 1);
            chk("rst_valid", out_valid, 0);
            chk("rst_rptr", rptr_gray, 0);
            chk("rst_en", mem_r_en, 0);
            chk("rst_addr", mem_r_addr, 0);
            chk("rst_data", out_data, 0);
            m_rcnt = '0;
            m_wq1 = '0;
            m_wq2 = '0;
            m_buf.delete();
            m_p1 = 0;
            prev_g = '0;
        end else begin
            e_empty = (gray(m_rcnt) == m_wq2);
            e_valid = (m_buf.size() > 0);
            e_pop   = e_valid && out_ready;
            e_en    = !e_empty && (m_buf.size() + int'(m_p1) - int'(e_pop) < 2);
            chk("empty", r_empty, e_empty);
            chk("r_en", mem_r_en, e_en);
            chk("addr", mem_r_addr, m_rcnt[AW-1:0]);
            chk("rptr", rptr_gray, gray(m_rcnt));
            chk("valid", out_valid, e_valid);
            if (e_valid) chk("data", out_data, m_buf[0]);
            if (mem_r_en) n_issue++;
            if (out_valid && out_ready) got.push_back(out_data);
            if (prev_g == 4'b1000 && rptr_gray == 4'b0000) seen_gwrap = 1;
            prev_g = rptr_gray;
            if (e_pop) void'(m_buf.pop_front());
            if (m_p1) m_buf.push_back(m_p1_data);
            m_p1 = e_en;
            if (e_en) begin
                m_p1_data = tbmem[m_rcnt[AW-1:0]];
                m_rcnt = m_rcnt + 1'b1;
            end
            m_wq2 = m_wq1;
            m_wq1 = wptr_gray_async;
        end
    end

    initial forever begin
        @(posedge r_clk);
        #1;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    task automatic do_reset();
        r_rst_n = 1'b0;
        wbin = '0;
        wptr_gray_async = '0;
        repeat (2) step();
        r_rst_n = 1'b1;
        step();
    endtask

    task automatic push(input logic [DW-1:0] d[$]);
        logic [PW-1:0] used;
        int t = 0;
        used = wbin - m_rcnt;
        while (int'(used) + d.size() > DEPTH && t < 500) begin
            step();
            used = wbin - m_rcnt;
            t++;
        end
        if (t >= 500) timeout("push_space");
        foreach (d[i]) begin
            tbmem[wbin[AW-1:0]] = d[i];
            wbin = wbin + 1'b1;
        end
        wptr_gray_async = gray(wbin);
    endtask

    task automatic drain();
        int t = 0;
        while (!(m_rcnt == wbin && m_buf.size() == 0 && !m_p1) && t < 500) begin
            step();
            t++;
        end
        if (t >= 500) timeout("drain");
        step();
    endtask

    task automatic wait_en(input string name);
        int t = 0;
        while (!mem_r_en && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) timeout(name);
    endtask

    task automatic chk_tail(input string name, input logic [DW-1:0] exp[$]);
        if (got.size() < exp.size()) begin
            chk({name, "_count"}, got.size(), exp.size());
        end else begin
            foreach (exp[i])
                chk(name, got[got.size() - exp.size() + i], exp[i]);
        end
    endtask

    logic [DW-1:0] words [$];
    logic [DW-1:0] all [$];
    int cyc;
    int n0;

    initial begin
        foreach (tbmem[i]) tbmem[i] = '0;
        // Reset and quiet hold
        r_rst_n = 1'b0;
        repeat (3) step();
        r_rst_n = 1'b1;
        repeat (3) step();
        chk("hold_empty", r_empty, 1);
        chk("hold_valid", out_valid, 0);

        // Single word
        out_ready = 1'b1;
        words = '{8'hA5};
        push(words);
        cyc = 0;
        while (r_empty && cyc < 10) begin
            step();
            cyc++;
        end
        chk("empty_lat", cyc, 2);
        chk("single_en", mem_r_en, 1);
        chk("single_addr", mem_r_addr, 0);
        step();
        chk("single_valid_n1", out_valid, 0);
        step();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'hA5);
        chk("single_rptr", rptr_gray, 4'b0001);
        chk("single_empty", r_empty, 1);
        drain();

        // Streaming 8 words from a clean pointer
        do_reset();
        words = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        push(words);
        chk("stream_wptr", wptr_gray_async, 4'b1100);
        wait_en("stream_start");
        for (int i = 0; i < 8; i++) begin
            chk("stream_en", mem_r_en, 1);
            chk("stream_addr", mem_r_addr, i);
            step();
        end
        chk("stream_stop", mem_r_en, 0);
        drain();
        chk_tail("stream_order", words);
        chk("stream_rptr", rptr_gray, 4'b1100);

        // Backpressure
        out_ready = 1'b0;
        words = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
        n0 = n_issue;
        push(words);
        repeat (12) step();
        chk("bp_reads", n_issue - n0, 2);
        chk("bp_valid", out_valid, 1);
        chk("bp_head", out_data, 8'h20);
        out_ready = 1'b1;
        drain();
        chk_tail("bp_order", words);

        // Wrap with random consumer
        all.delete();
        rand_mode = 1;
        foreach (words[i]) words[i] = '0;
        for (int b = 0; b < 3; b++) begin
            words.delete();
            for (int i = 0; i < ((b == 2) ? 4 : 8); i++)
                words.push_back(8'($urandom));
            all = {all, words};
            push(words);
        end
        drain();
        rand_mode = 0;
        out_ready = 1'b1;
        drain();
        chk_tail("wrap_order", all);
        chk("wrap_gray", seen_gwrap, 1);

        // Reset with a read in flight
        do_reset();
        words = '{8'h31, 8'h32, 8'h33, 8'h34};
        push(words);
        wait_en("mid_start");
        step();
        r_rst_n = 1'b0;
        wbin = '0;
        wptr_gray_async = '0;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_empty", r_empty, 1);
        chk("mid_en", mem_r_en, 0);
        chk("mid_rptr", rptr_gray, 0);
        repeat (2) step();
        r_rst_n = 1'b1;
        step();
        words = '{8'h5A};
        push(words);
        wait_en("post_start");
        chk("post_addr", mem_r_addr, 0);
        drain();
        chk_tail("post_data", words);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
